// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment byte layout is {a,b,c,d,e,f,g,dp}, all active low.
package seven_seg_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit positions inside the 8-bit segment byte
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-low a..g patterns for each hex digit
    localparam logic [6:0] HEX7_0 = 7'b0000001;
    localparam logic [6:0] HEX7_1 = 7'b1001111;
    localparam logic [6:0] HEX7_2 = 7'b0010010;
    localparam logic [6:0] HEX7_3 = 7'b0000110;
    localparam logic [6:0] HEX7_4 = 7'b1001100;
    localparam logic [6:0] HEX7_5 = 7'b0100100;
    localparam logic [6:0] HEX7_6 = 7'b0100000;
    localparam logic [6:0] HEX7_7 = 7'b0001111;
    localparam logic [6:0] HEX7_8 = 7'b0000000;
    localparam logic [6:0] HEX7_9 = 7'b0000100;
    localparam logic [6:0] HEX7_A = 7'b0001000;
    localparam logic [6:0] HEX7_B = 7'b1100000;
    localparam logic [6:0] HEX7_C = 7'b0110001;
    localparam logic [6:0] HEX7_D = 7'b1000010;
    localparam logic [6:0] HEX7_E = 7'b0110000;
    localparam logic [6:0] HEX7_F = 7'b0111000;

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return HEX7_0;
            4'h1:    return HEX7_1;
            4'h2:    return HEX7_2;
            4'h3:    return HEX7_3;
            4'h4:    return HEX7_4;
            4'h5:    return HEX7_5;
            4'h6:    return HEX7_6;
            4'h7:    return HEX7_7;
            4'h8:    return HEX7_8;
            4'h9:    return HEX7_9;
            4'hA:    return HEX7_A;
            4'hB:    return HEX7_B;
            4'hC:    return HEX7_C;
            4'hD:    return HEX7_D;
            4'hE:    return HEX7_E;
            default: return HEX7_F;
        endcase
    endfunction

    // Counter width that still works for a count of one
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module hex_to_seg
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segments
);

    always_comb begin
        segments                = SEG_BLANK;
        segments[SEG_A:SEG_G]   = hex7(nibble);
        segments[SEG_DP]        = ~dp;
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit seven-segment scanner with frame snapshots, per-digit
// blanking, optional leading-zero suppression and anti-ghosting dead time.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int BLANK_CYCLES     = 1000,
    parameter int LZ_SUPPRESS      = 0,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic [7:0]                segments,
    output logic                      frame_tick
);

    localparam int PRESC_W = width_of(REFRESH_DIV);
    localparam int IDX_W   = width_of(NUM_DIGITS);

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0]    PRESC_OPEN = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] snap_value;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;

    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   dark;
    logic                    zero_run;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_dark;
    logic [7:0]              cur_pattern;
    logic                    show;
    logic [NUM_DIGITS-1:0]   anodes_next;
    logic [7:0]              segments_next;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Prescaler and digit index; both parked at zero while disabled
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (!enable) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Frame snapshot: follows the inputs while idle, otherwise reloads only at
    // the last cycle of the last slot so a frame never mixes old and new data.
    // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset to a
    // known value; nothing stale can reach the display after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
        end else if (!enable || frame_end) begin
            snap_value <= value;
            snap_dp    <= dp_in;
            snap_blank <= blank_in;
        end
    end

    // A digit is dark when forced, or when it belongs to the zero run at the top
    // of the number (digit 0 excluded so a zero value still reads "0").
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dark     = snap_blank;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_value[4*i +: 4] == 4'h0);
            if ((LZ_SUPPRESS != 0) && (i > 0) && zero_run) begin
                dark[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = snap_value[4*i +: 4];
                cur_dp     = snap_dp[i];
                cur_dark   = dark[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble   (cur_nibble),
        .dp       (cur_dp),
        .segments (cur_pattern)
    );

    // Dead time at the start of each slot keeps the previous digit's pattern
    // from ghosting onto the newly selected anode.
    assign show          = enable && (presc >= PRESC_OPEN) && !cur_dark;
    assign anodes_next   = show ? ((NUM_DIGITS'(1) << idx) ^ ANODES_OFF) : ANODES_OFF;
    assign segments_next = show ? cur_pattern : SEG_BLANK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodes     <= ANODES_OFF;
            segments   <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            anodes     <= anodes_next;
            segments   <= segments_next;
            frame_tick <= enable && frame_end;
        end
    end

endmodule
